// File: rtl/aclk_time_counter.sv
// ---------------------------------------------------------------------------
// aclk_time_counter
// Time-of-day register for the alarm clock, held as four BCD digits (HH:MM,
// 24-hour). The counter advances one minute per one_minute pulse and can be
// overwritten by a load request from the control FSM. Range checking is done
// at load time, so the digits always stay legal and every carry is exact.
//
// Ports:
//   clk          system clock (256 cycles = 1 s)
//   reset        asynchronous, active-high reset
//   one_minute   single-cycle minute-advance pulse from the time generator
//   load_new_c   single-cycle request to load the new_* digits
//   new_ms_hr    load value, tens of hours   (0-2)
//   new_ls_hr    load value, units of hours  (0-9)
//   new_ms_min   load value, tens of minutes (0-5)
//   new_ls_min   load value, units of minutes (0-9)
//   ms_hr        current tens of hours
//   ls_hr        current units of hours
//   ms_min       current tens of minutes
//   ls_min       current units of minutes
//   load_err     one-cycle pulse: a load request was rejected
//   day_wrap     one-cycle pulse: the time rolled over 23:59 -> 00:00
// ---------------------------------------------------------------------------
module aclk_time_counter #(
    parameter int unsigned RESET_HR  = 0,
    parameter int unsigned RESET_MIN = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_minute,
    input  logic       load_new_c,
    input  logic [1:0] new_ms_hr,
    input  logic [3:0] new_ls_hr,
    input  logic [2:0] new_ms_min,
    input  logic [3:0] new_ls_min,
    output logic [1:0] ms_hr,
    output logic [3:0] ls_hr,
    output logic [2:0] ms_min,
    output logic [3:0] ls_min,
    output logic       load_err,
    output logic       day_wrap
);

    // Reset digits derived from the binary reset time.
    localparam logic [1:0] RST_MS_HR  = 2'(RESET_HR / 10);
    localparam logic [3:0] RST_LS_HR  = 4'(RESET_HR % 10);
    localparam logic [2:0] RST_MS_MIN = 3'(RESET_MIN / 10);
    localparam logic [3:0] RST_LS_MIN = 4'(RESET_MIN % 10);

    // Digit limits.
    localparam logic [3:0] LS_MAX     = 4'd9;
    localparam logic [2:0] MS_MIN_MAX = 3'd5;
    localparam logic [1:0] MS_HR_MAX  = 2'd2;
    localparam logic [3:0] LS_HR_TOP  = 4'd3;

    logic       load_valid_c;
    logic       do_load_c;
    logic       do_inc_c;

    logic       min_carry_c;
    logic       hr_carry_c;
    logic       wrap_c;

    logic [1:0] ms_hr_nxt;
    logic [3:0] ls_hr_nxt;
    logic [2:0] ms_min_nxt;
    logic [3:0] ls_min_nxt;
    logic       load_err_nxt;
    logic       day_wrap_nxt;

    // Load request validation: every digit in range and no hour above 23.
    always_comb begin
        load_valid_c = (new_ls_min <= LS_MAX)
                    && (new_ms_min <= MS_MIN_MAX)
                    && (new_ls_hr  <= LS_MAX)
                    && (new_ms_hr  <= MS_HR_MAX)
                    && !((new_ms_hr == MS_HR_MAX) && (new_ls_hr > LS_HR_TOP));
    end

    // A valid load takes priority and swallows a coincident minute pulse;
    // a rejected load leaves the minute pulse free to advance the time.
    assign do_load_c = load_new_c && load_valid_c;
    assign do_inc_c  = one_minute && !do_load_c;

    // Ripple-carry conditions through the digit chain.
    assign min_carry_c = (ls_min == LS_MAX);
    assign hr_carry_c  = min_carry_c && (ms_min == MS_MIN_MAX);
    assign wrap_c      = hr_carry_c && (ms_hr == MS_HR_MAX) && (ls_hr == LS_HR_TOP);

    // Next-state selection: hold, load, or single-minute increment.
    always_comb begin
        ms_hr_nxt    = ms_hr;
        ls_hr_nxt    = ls_hr;
        ms_min_nxt   = ms_min;
        ls_min_nxt   = ls_min;
        load_err_nxt = load_new_c && !load_valid_c;
        day_wrap_nxt = 1'b0;

        if (do_load_c) begin
            ms_hr_nxt  = new_ms_hr;
            ls_hr_nxt  = new_ls_hr;
            ms_min_nxt = new_ms_min;
            ls_min_nxt = new_ls_min;
        end else if (do_inc_c) begin
            // Units of minutes.
            if (min_carry_c) begin
                ls_min_nxt = 4'd0;
            end else begin
                ls_min_nxt = ls_min + 4'd1;
            end

            // Tens of minutes.
            if (min_carry_c) begin
                if (ms_min == MS_MIN_MAX) begin
                    ms_min_nxt = 3'd0;
                end else begin
                    ms_min_nxt = ms_min + 3'd1;
                end
            end

            // Hours, including the end-of-day rollover.
            if (hr_carry_c) begin
                if (wrap_c) begin
                    ms_hr_nxt    = 2'd0;
                    ls_hr_nxt    = 4'd0;
                    day_wrap_nxt = 1'b1;
                end else if (ls_hr == LS_MAX) begin
                    ls_hr_nxt = 4'd0;
                    ms_hr_nxt = ms_hr + 2'd1;
                end else begin
                    ls_hr_nxt = ls_hr + 4'd1;
                end
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_hr    <= RST_MS_HR;
            ls_hr    <= RST_LS_HR;
            ms_min   <= RST_MS_MIN;
            ls_min   <= RST_LS_MIN;
            load_err <= 1'b0;
            day_wrap <= 1'b0;
        end else begin
            ms_hr    <= ms_hr_nxt;
            ls_hr    <= ls_hr_nxt;
            ms_min   <= ms_min_nxt;
            ls_min   <= ls_min_nxt;
            load_err <= load_err_nxt;
            day_wrap <= day_wrap_nxt;
        end
    end

endmodule
